byte_serial_adder_ctrl: RTL and testbench



---
 rtl/byte_serial_adder_ctrl_if.sv | 28 ++
 rtl/byte_serial_adder_ctrl.sv | 112 +++++++++++
 tb/tb_byte_serial_adder_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/byte_serial_adder_ctrl_if.sv
// Operand/result handshake bundle for byte_serial_adder_ctrl.
//   in_valid/in_ready : operand pair handshake (in_a, in_b, in_cin)
//   out_valid/out_ready : result handshake (out_sum, out_cout)
// master = environment side (produces operands, consumes result)
// slave  = controller side
interface byte_serial_adder_ctrl_if #(
  parameter int unsigned NBYTES = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [8*NBYTES-1:0]   in_a;
  logic [8*NBYTES-1:0]   in_b;
  logic                  in_cin;
  logic                  out_valid;
  logic                  out_ready;
  logic [8*NBYTES-1:0]   out_sum;
  logic                  out_cout;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout
  );
endinterface

// File: rtl/byte_serial_adder_ctrl.sv
// Byte-serial wide adder controller. Streams NBYTES-wide operands one byte
// per cycle through an external combinational 8-bit adder, chaining the
// carry, and presents the full sum on a valid/ready result port.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   bus (slave)         operand and result handshakes (see interface)
//   add_a, add_b        byte operands to the external adder
//   add_cin             carry into the external adder
//   add_s, add_cout     combinational result of the external adder
module byte_serial_adder_ctrl #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  byte_serial_adder_ctrl_if.slave  bus,
  output logic [7:0]               add_a,
  output logic [7:0]               add_b,
  output logic                     add_cin,
  input  logic [7:0]               add_s,
  input  logic                     add_cout
);
  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  state_t        next_state;
  logic [7:0]    a_reg   [NBYTES];
  logic [7:0]    b_reg   [NBYTES];
  logic [7:0]    sum_reg [NBYTES];
  logic          carry;
  logic [IW-1:0] idx;
  logic          accept;

  assign accept = bus.in_valid && bus.in_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = RUN;
      RUN:  if (idx == LAST) next_state = DONE;
      DONE: if (bus.out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: operand capture, per-byte sum capture, carry chaining
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        a_reg[i]   <= '0;
        b_reg[i]   <= '0;
        sum_reg[i] <= '0;
      end
      carry <= 1'b0;
      idx   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            for (int unsigned i = 0; i < NBYTES; i++) begin
              a_reg[i] <= bus.in_a[8*i +: 8];
              b_reg[i] <= bus.in_b[8*i +: 8];
            end
            carry <= bus.in_cin;
            idx   <= '0;
          end
        end
        RUN: begin
          sum_reg[idx] <= add_s;
          carry        <= add_cout;
          idx          <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs. in_ready is gated by rst_n so it reads 0 while reset is held,
  // even though the state register already sits in IDLE.
  always_comb begin
    bus.in_ready  = (state == IDLE) && rst_n;
    bus.out_valid = (state == DONE);
    bus.out_sum   = '0;
    bus.out_cout  = 1'b0;
    add_a         = '0;
    add_b         = '0;
    add_cin       = 1'b0;
    if (state == DONE) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        bus.out_sum[8*i +: 8] = sum_reg[i];
      end
      bus.out_cout = carry;
    end
    if (state == RUN) begin
      add_a   = a_reg[idx];
      add_b   = b_reg[idx];
      add_cin = carry;
    end
  end
endmodule

// File: tb/tb_byte_serial_adder_ctrl.sv
module tb_byte_serial_adder_ctrl;
  localparam int unsigned NB = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] add_a, add_b, add_s;
  logic       add_cin, add_cout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  byte_serial_adder_ctrl_if #(.NBYTES(NB)) bus ();

  byte_serial_adder_ctrl #(.NBYTES(NB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_s    (add_s),
    .add_cout (add_cout)
  );

  // Stand-in for the external combinational 8-bit adder
  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Carry entering byte k: the high part of the sum of the low k bytes
  function automatic logic carry_into(input logic [31:0] a, input logic [31:0] b,
                                      input logic cin, input int k);
    logic [63:0] m;
    logic [63:0] t;
    m = (64'd1 << (8*k)) - 64'd1;
    t = ({32'd0, a} & m) + ({32'd0, b} & m) + {63'd0, cin};
    return t[8*k];
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                        input int hold, input bit poke,
                        output logic [31:0] s, output logic c);
    logic [63:0] full;
    int cnt;
    full = {32'd0, a} + {32'd0, b} + {63'd0, cin};
    chk("in_ready_idle", {63'd0, bus.in_ready}, 64'd1);
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_cin    = cin;
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    cnt = 0;
    while (bus.out_valid !== 1'b1 && cnt < 3*NB + 4) begin
      if (cnt < NB) begin
        chk("add_a",    {56'd0, add_a}, {56'd0, 8'((a >> (8*cnt)))});
        chk("add_b",    {56'd0, add_b}, {56'd0, 8'((b >> (8*cnt)))});
        chk("add_cin",  {63'd0, add_cin}, {63'd0, carry_into(a, b, cin, cnt)});
        chk("in_ready_run", {63'd0, bus.in_ready}, 64'd0);
      end
      if (poke && cnt == 1) begin
        bus.in_valid = 1'b1;
        bus.in_a     = ~a;
        bus.in_b     = a ^ 32'h5A5A_5A5A;
        bus.in_cin   = ~cin;
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
      cnt++;
    end
    bus.in_valid = 1'b0;
    chk("latency", 64'(cnt), 64'(NB));
    s = bus.out_sum;
    c = bus.out_cout;
    chk("out_sum",  {32'd0, s}, {32'd0, full[31:0]});
    chk("out_cout", {63'd0, c}, {63'd0, full[32]});
    chk("add_idle", {47'd0, add_a, add_b, add_cin}, 64'd0);
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("hold_sum",   {32'd0, bus.out_sum}, {32'd0, s});
      chk("hold_cout",  {63'd0, bus.out_cout}, {63'd0, c});
      chk("hold_in_ready", {63'd0, bus.in_ready}, 64'd0);
    end
    bus.out_ready = 1'b1;
    step();
    chk("valid_after", {63'd0, bus.out_valid}, 64'd0);
    chk("in_ready_after", {63'd0, bus.in_ready}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] s;
    logic        c;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_in_ready",  {63'd0, bus.in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_out_sum",   {32'd0, bus.out_sum}, 64'd0);
    chk("rst_out_cout",  {63'd0, bus.out_cout}, 64'd0);
    chk("rst_add",       {47'd0, add_a, add_b, add_cin}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

    vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
    vecs[2] = '{32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'h00FF_00FF, 32'h0001_0001, 1'b1, 32'h0100_0101, 1'b0};
    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, 0, 1'b0, s, c);
      chk("vec_sum",  {32'd0, s}, {32'd0, vecs[i].sum});
      chk("vec_cout", {63'd0, c}, {63'd0, vecs[i].cout});
    end

    // Back-pressure: DONE held for 5 cycles
    run_op(32'hDEAD_BEEF, 32'h1111_1111, 1'b1, 5, 1'b0, s, c);
    chk("bp_sum", {32'd0, s}, 64'h0000_0000_EFBE_D001);

    // in_valid pulsed mid-RUN with other operands must be ignored
    run_op(32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b1, 0, 1'b1, s, c);
    chk("poke_sum",  {32'd0, s}, 64'd0);
    chk("poke_cout", {63'd0, c}, 64'd1);

    // Reset after two RUN cycles
    bus.in_valid = 1'b1;
    bus.in_a     = 32'h0102_0304;
    bus.in_b     = 32'h1111_1111;
    bus.in_cin   = 1'b0;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid",    {63'd0, bus.out_valid}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("mid_rst_add",      {47'd0, add_a, add_b, add_cin}, 64'd0);
    step();
    chk("mid_rst_hold_add", {47'd0, add_a, add_b, add_cin}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("rel_in_ready", {63'd0, bus.in_ready}, 64'd1);
    run_op(32'h0000_0001, 32'h0000_0001, 1'b0, 0, 1'b0, s, c);
    chk("rel_sum", {32'd0, s}, 64'd2);

    // Randomized operations against the reference arithmetic
    for (int i = 0; i < 40; i++) begin
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), s, c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
